hv_mem_stream_reader: RTL

Read-side sequencer for the single-port synchronous hypervector RAM. Accepts a burst command (start address, word count), drives the RAM's chip-select/output-enable/address pins, absorbs the RAM's one-cycle registered read latency and streams the words to the downstream compute stage over a valid/ready interface with full backpressure. Sits directly between the RAM and the encoder/similarity datapath that consumes stored hypervectors.

---
 rtl/hv_mem_stream_reader.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/hv_mem_stream_reader.sv
// rtl/hv_mem_stream_reader.sv - burst read sequencer from the hypervector RAM to a valid/ready stream
//
// Accepts a (start address, word count) command, issues single-cycle reads to the
// synchronous RAM, absorbs its one-cycle read latency and streams the words out
// through a 2-entry {data, last} buffer with full backpressure.
//
// Optional feature macro: HV_RD_WRAP_EN
//   defined   : bursts may run past the last RAM word and wrap to address 0
//   undefined : a command with cmd_addr + cmd_len > RAM depth is rejected
//
// Ports:
//   clk_i, rst_n_i             clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o  command handshake; cmd_addr_i first word, cmd_len_i word count
//   cmd_err_o                  one-cycle pulse after a rejected command
//   busy_o                     burst in progress
//   mem_address_o, mem_cs_o,
//   mem_we_o, mem_oe_o         RAM control (write enable tied low)
//   mem_rdata_i                RAM registered read data
//   out_valid_o / out_ready_i  output stream handshake; out_data_o word, out_last_o final word
module hv_mem_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    output logic                  cmd_err_o,
    output logic                  busy_o,
    output logic [ADDR_WIDTH-1:0] mem_address_o,
    output logic                  mem_cs_o,
    output logic                  mem_we_o,
    output logic                  mem_oe_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_last_o
);

    localparam logic [LEN_WIDTH:0] DEPTH = (LEN_WIDTH+1)'(1 << ADDR_WIDTH);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH-1:0]   addr_hold_q, addr_hold_d;
    logic [LEN_WIDTH-1:0]    remaining_q, remaining_d;
    logic                    inflight_q, inflight_d;
    logic                    inflight_last_q, inflight_last_d;
    logic                    cmd_err_q, cmd_err_d;
    logic [1:0]              count_q, count_d;
    logic [DATA_WIDTH-1:0]   data0_q, data0_d, data1_q, data1_d;
    logic                    last0_q, last0_d, last1_q, last1_d;

    logic                    pop;
    logic                    credit;
    logic                    issue;
    logic                    range_bad;
    logic                    cmd_bad;
    logic [1:0]              wr_sel;

`ifdef HV_RD_WRAP_EN
    assign range_bad = 1'b0;
`else
    logic [LEN_WIDTH:0] end_ext;
    assign end_ext   = {1'b0, cmd_len_i} + (LEN_WIDTH+1)'(cmd_addr_i);
    assign range_bad = (end_ext > DEPTH);
`endif

    assign cmd_bad = (cmd_len_i == '0) || ({1'b0, cmd_len_i} > DEPTH) || range_bad;

    assign pop    = (count_q != 2'd0) && out_ready_i;
    // Words already buffered plus the one still coming back from the RAM must
    // leave room for the new read once this cycle's pop is accounted for.
    assign credit = ({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
    assign issue  = (state_q == READ) && (remaining_q != '0) && credit;

    always_comb begin
        state_d         = state_q;
        rd_addr_d       = rd_addr_q;
        addr_hold_d     = addr_hold_q;
        remaining_d     = remaining_q;
        cmd_err_d       = 1'b0;
        inflight_d      = issue;
        inflight_last_d = issue && (remaining_q == LEN_WIDTH'(1));
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    if (cmd_bad) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        rd_addr_d   = cmd_addr_i;
                        remaining_d = cmd_len_i;
                        state_d     = READ;
                    end
                end
            end
            READ: begin
                if (issue) begin
                    addr_hold_d = rd_addr_q;
                    rd_addr_d   = rd_addr_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!inflight_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output buffer: slot 0 is the head; a pop shifts slot 1 down and the
    // returning RAM word lands in the first free slot after that shift.
    always_comb begin
        data0_d = data0_q;
        data1_d = data1_q;
        last0_d = last0_q;
        last1_d = last1_q;
        wr_sel  = count_q - {1'b0, pop};
        if (pop) begin
            data0_d = data1_q;
            last0_d = last1_q;
        end
        if (inflight_q) begin
            if (wr_sel == 2'd0) begin
                data0_d = mem_rdata_i;
                last0_d = inflight_last_q;
            end else begin
                data1_d = mem_rdata_i;
                last1_d = inflight_last_q;
            end
        end
        count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q         <= IDLE;
            rd_addr_q       <= '0;
            addr_hold_q     <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            cmd_err_q       <= 1'b0;
            count_q         <= 2'd0;
            data0_q         <= '0;
            data1_q         <= '0;
            last0_q         <= 1'b0;
            last1_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            rd_addr_q       <= rd_addr_d;
            addr_hold_q     <= addr_hold_d;
            remaining_q     <= remaining_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            cmd_err_q       <= cmd_err_d;
            count_q         <= count_d;
            data0_q         <= data0_d;
            data1_q         <= data1_d;
            last0_q         <= last0_d;
            last1_q         <= last1_d;
        end
    end

    assign cmd_ready_o   = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign cmd_err_o     = cmd_err_q;
    assign mem_cs_o      = issue;
    assign mem_oe_o      = issue;
    assign mem_we_o      = 1'b0;
    assign mem_address_o = issue ? rd_addr_q : addr_hold_q;
    assign out_valid_o   = (count_q != 2'd0);
    assign out_data_o    = out_valid_o ? data0_q : '0;
    assign out_last_o    = out_valid_o && last0_q;

endmodule
